// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module  : router_pkg
// Brief   : Shared types and header-field constants for the router reader.
// Revision: 1.0
// ============================================================================
package router_pkg;

    localparam int DATA_W         = 8;
    localparam int HDR_LEN_MSB    = 7;
    localparam int HDR_LEN_LSB    = 2;
    localparam int HDR_ADDR_MSB   = 1;
    localparam int ROUTER_TIMEOUT = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/router_rd_timer.sv
`default_nettype none
// ============================================================================
// Module  : router_rd_timer
// Brief   : Loadable delay down-counter plus saturating stall counter.
// Revision: 1.0
// ============================================================================
module router_rd_timer #(
    parameter int DLY_W     = 5,
    parameter int STALL_MAX = 32,
    parameter int STALL_W   = $clog2(STALL_MAX)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             dly_load,
    input  logic [DLY_W-1:0] dly_val,
    input  logic             dly_dec,
    output logic             dly_zero,
    input  logic             stall_inc,
    input  logic             stall_clr,
    output logic             stall_term
);

    logic [DLY_W-1:0]   dly_cnt;
    logic [STALL_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dly_cnt <= '0;
        end else if (dly_load) begin
            dly_cnt <= dly_val;
        end else if (dly_dec && (dly_cnt != '0)) begin
            dly_cnt <= dly_cnt - 1'b1;
        end
    end

    // Saturates at the terminal value so the flag stays up until cleared.
    always_ff @(posedge clk) begin
        if (!rstn || stall_clr) begin
            stall_cnt <= '0;
        end else if (stall_inc && !stall_term) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign dly_zero   = (dly_cnt == '0);
    assign stall_term = (stall_cnt == STALL_W'(STALL_MAX - 1));

endmodule
`default_nettype wire

// File: rtl/router_dest_reader.sv
`default_nettype none
// ============================================================================
// Module  : router_dest_reader
// Brief   : Drains one packet per vld_out episode, streams payload, checks parity.
// Revision: 1.0
// ============================================================================
module router_dest_reader
    import router_pkg::*;
#(
    parameter int DATA_W    = router_pkg::DATA_W,
    parameter int LEN_W     = 6,
    parameter int STALL_MAX = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              vld_out,
    input  logic [DATA_W-1:0] data_out,
    input  logic [4:0]        rd_delay,
    input  logic              hold,
    output logic              read_enb,
    output logic [DATA_W-1:0] pyld_data,
    output logic              pyld_valid,
    output logic [LEN_W-1:0]  pkt_len,
    output logic [1:0]        pkt_addr,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic              pkt_abort,
    output logic              busy
);

    localparam int CNT_W = LEN_W + 1;

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  got;
    logic [CNT_W-1:0]  limit;
    logic              rd_q;
    logic [DATA_W-1:0] par_acc;
    logic              want_more;
    logic              is_parity;
    logic              abort_nxt;
    logic              dly_load;
    logic              dly_dec;
    logic              dly_zero;
    logic              stall_inc;
    logic              stall_clr;
    logic              stall_term;

    // Only the header may be in flight until its length is known.
    assign limit     = (got == '0) ? CNT_W'(1) : (CNT_W'(pkt_len) + CNT_W'(2));
    assign want_more = (issued < limit);
    assign is_parity = rd_q && (got == (CNT_W'(pkt_len) + CNT_W'(1)));
    assign busy      = (state != IDLE);

    router_rd_timer #(
        .DLY_W     (5),
        .STALL_MAX (STALL_MAX)
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .dly_load   (dly_load),
        .dly_val    (rd_delay),
        .dly_dec    (dly_dec),
        .dly_zero   (dly_zero),
        .stall_inc  (stall_inc),
        .stall_clr  (stall_clr),
        .stall_term (stall_term)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        read_enb  = 1'b0;
        dly_load  = 1'b0;
        dly_dec   = 1'b0;
        stall_inc = 1'b0;
        stall_clr = 1'b1;
        abort_nxt = 1'b0;
        pkt_done  = 1'b0;
        pkt_err   = 1'b0;
        case (state)
            IDLE: begin
                if (vld_out) begin
                    state_nxt = WAIT;
                    dly_load  = 1'b1;
                end
            end
            WAIT: begin
                if (!vld_out) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (dly_zero) begin
                    state_nxt = READ;
                end else begin
                    dly_dec = 1'b1;
                end
            end
            READ: begin
                stall_clr = vld_out;
                read_enb  = vld_out & ~hold & want_more;
                if (is_parity) begin
                    state_nxt = DONE;
                end else if (!vld_out && want_more) begin
                    stall_inc = 1'b1;
                    if (stall_term) begin
                        state_nxt = IDLE;
                        abort_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                pkt_done  = 1'b1;
                pkt_err   = (par_acc != '0) | (pkt_len == '0);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            issued     <= '0;
            got        <= '0;
            rd_q       <= 1'b0;
            par_acc    <= '0;
            pkt_len    <= '0;
            pkt_addr   <= '0;
            pyld_data  <= '0;
            pyld_valid <= 1'b0;
            pkt_abort  <= 1'b0;
        end else begin
            pkt_abort  <= abort_nxt;
            pyld_valid <= 1'b0;
            // par_acc survives the DONE cycle and is cleared on the way out.
            if (state != READ) begin
                issued  <= '0;
                got     <= '0;
                rd_q    <= 1'b0;
                par_acc <= '0;
            end else begin
                rd_q <= read_enb;
                if (read_enb) begin
                    issued <= issued + 1'b1;
                end
                if (rd_q) begin
                    got     <= got + 1'b1;
                    par_acc <= par_acc ^ data_out;
                    if (got == '0) begin
                        pkt_len  <= LEN_W'(data_out[HDR_LEN_MSB:HDR_LEN_LSB]);
                        pkt_addr <= data_out[HDR_ADDR_MSB:0];
                    end else if (got <= CNT_W'(pkt_len)) begin
                        pyld_data  <= data_out;
                        pyld_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
